count_mod_ud: RTL and testbench

Parametrised up/down modulo counter with prescaler, synchronous load and cascade outputs. It is the general-purpose successor of the LED-display counter: it drives digit/column scan indices, refresh dividers and chained BCD-style digit counters. All state updates occur on the falling edge of `clk`, so it samples cleanly against rising-edge producers in the display path.

---
 rtl/count_mod_ud.sv | 124 ++++++++++++
 tb/tb_count_mod_ud.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_mod_ud.sv
// ---------------------------------------------------------------------------
// count_mod_ud
// Up/down modulo counter with prescaler, synchronous load and cascade
// outputs. Drives display scan indices, refresh dividers and chained
// digit counters. Every register updates on the falling edge of clk, so the
// counter samples cleanly against rising-edge producers in the display path.
//
// Parameters
//   WIDTH   counter width in bits
//   MODULO  count range 0..MODULO-1 (2..2^WIDTH)
//   PRESC   enabled cycles per count step (1..65535)
//
// Ports
//   clk    in   clock, registers update on the falling edge
//   reset  in   synchronous active-high reset
//   en     in   count enable, advances the prescaler
//   dir    in   1 = count up, 0 = count down
//   load   in   synchronous load of din (clamped to MODULO-1)
//   din    in   load value
//   sat    in   saturate mode select (only with COUNT_MOD_SAT_EN)
//   outc   out  current count (registered)
//   zero   out  outc == 0
//   tc     out  terminal count: a step this cycle would wrap (cascade enable)
//   wrap   out  one-cycle registered pulse after a wrap
//
// Build option
//   COUNT_MOD_SAT_EN  when defined, sat=1 holds the counter at its limit
//                     instead of wrapping; otherwise sat is ignored.
// ---------------------------------------------------------------------------
module count_mod_ud #(
    parameter int WIDTH  = 5,
    parameter int MODULO = 32,
    parameter int PRESC  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             sat,
    output logic [WIDTH-1:0] outc,
    output logic             zero,
    output logic             tc,
    output logic             wrap
);

    localparam int PW = 16;
    // Limits are held in WIDTH+1 bits so MODULO = 2^WIDTH is representable.
    localparam logic [WIDTH:0]  MOD_LAST = (WIDTH+1)'(MODULO - 1);
    localparam logic [PW-1:0]   PSC_LAST = PW'(PRESC - 1);

    logic [PW-1:0]  psc;
    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] din_ext;
    logic [WIDTH:0] load_val;
    logic [WIDTH:0] step_val;
    logic           at_top;
    logic           at_bot;
    logic           psc_last;
    logic           at_limit;
    logic           sat_on;

`ifdef COUNT_MOD_SAT_EN
    assign sat_on = sat;
`else
    logic unused_sat;
    assign unused_sat = sat;
    assign sat_on     = 1'b0;
`endif

    assign cnt_ext  = {1'b0, outc};
    assign din_ext  = {1'b0, din};
    assign at_top   = (cnt_ext == MOD_LAST);
    assign at_bot   = (outc == '0);
    assign psc_last = (psc == PSC_LAST);
    assign at_limit = dir ? at_top : at_bot;

    assign zero = at_bot;
    // Saturation suppresses the cascade enable: a held stage must not
    // advance the next one.
    assign tc   = en & psc_last & at_limit & ~sat_on;

    assign load_val = (din_ext > MOD_LAST) ? MOD_LAST : din_ext;

    always_comb begin
        step_val = cnt_ext;
        if (dir) begin
            if (at_top)
                step_val = sat_on ? cnt_ext : '0;
            else
                step_val = cnt_ext + 1'b1;
        end else begin
            if (at_bot)
                step_val = sat_on ? cnt_ext : MOD_LAST;
            else
                step_val = cnt_ext - 1'b1;
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            outc <= '0;
            psc  <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            outc <= load_val[WIDTH-1:0];
            psc  <= '0;
            wrap <= 1'b0;
        end else if (en) begin
            if (psc_last) begin
                psc  <= '0;
                outc <= step_val[WIDTH-1:0];
                wrap <= at_limit & ~sat_on;
            end else begin
                psc  <= psc + 1'b1;
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_count_mod_ud.sv
// ---------------------------------------------------------------------------
// tb_count_mod_ud
// Bench for count_mod_ud. Four instances share one stimulus:
//   u_a  WIDTH=4 MODULO=10 PRESC=1  (cascade stage 0)
//   u_b  WIDTH=4 MODULO=10 PRESC=3
//   u_c  WIDTH=5 MODULO=32 PRESC=1
//   u_s1 WIDTH=4 MODULO=10 PRESC=1  (cascade stage 1, en = u_a.tc)
// A behavioural model predicts each edge; expected registered outputs are
// queued when stimulus is applied and compared after the falling edge.
// ---------------------------------------------------------------------------
module tb_count_mod_ud;

    logic       clk = 1'b0;
    logic       reset, en, dir, load, sat;
    logic [4:0] din;

    logic [3:0] a_outc, b_outc, s1_outc;
    logic [4:0] c_outc;
    logic       a_zero, a_tc, a_wrap;
    logic       b_zero, b_tc, b_wrap;
    logic       c_zero, c_tc, c_wrap;
    logic       s1_zero, s1_tc, s1_wrap;
    logic       s1_en;
    logic [3:0] s1_din;

    assign s1_en  = a_tc;
    assign s1_din = 4'd0;

    always #5 clk = ~clk;

    count_mod_ud #(.WIDTH(4), .MODULO(10), .PRESC(1)) u_a (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .din(din[3:0]), .sat(sat), .outc(a_outc), .zero(a_zero),
        .tc(a_tc), .wrap(a_wrap));

    count_mod_ud #(.WIDTH(4), .MODULO(10), .PRESC(3)) u_b (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .din(din[3:0]), .sat(sat), .outc(b_outc), .zero(b_zero),
        .tc(b_tc), .wrap(b_wrap));

    count_mod_ud #(.WIDTH(5), .MODULO(32), .PRESC(1)) u_c (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .din(din), .sat(sat), .outc(c_outc), .zero(c_zero),
        .tc(c_tc), .wrap(c_wrap));

    count_mod_ud #(.WIDTH(4), .MODULO(10), .PRESC(1)) u_s1 (
        .clk(clk), .reset(reset), .en(s1_en), .dir(1'b1), .load(1'b0),
        .din(s1_din), .sat(1'b0), .outc(s1_outc), .zero(s1_zero),
        .tc(s1_tc), .wrap(s1_wrap));

    // Model configuration per instance index
    int modv[4] = '{10, 10, 32, 10};
    int prv[4]  = '{1, 3, 1, 1};
    int wv[4]   = '{4, 4, 5, 4};

    int m_out[4];
    int m_psc[4];
    int m_wrap[4];
    bit model_valid = 1'b0;

    typedef struct {
        int idx;
        int outc;
        int wrap;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dut_outc(int i);
        case (i)
            0: return int'(a_outc);
            1: return int'(b_outc);
            2: return int'(c_outc);
            default: return int'(s1_outc);
        endcase
    endfunction

    function automatic int dut_tc(int i);
        case (i)
            0: return int'(a_tc);
            1: return int'(b_tc);
            2: return int'(c_tc);
            default: return int'(s1_tc);
        endcase
    endfunction

    function automatic int dut_zero(int i);
        case (i)
            0: return int'(a_zero);
            1: return int'(b_zero);
            2: return int'(c_zero);
            default: return int'(s1_zero);
        endcase
    endfunction

    function automatic int dut_wrap(int i);
        case (i)
            0: return int'(a_wrap);
            1: return int'(b_wrap);
            2: return int'(c_wrap);
            default: return int'(s1_wrap);
        endcase
    endfunction

    function automatic int m_tc(int i, bit e, bit d, bit se);
        bit lim;
        lim = d ? (m_out[i] == modv[i] - 1) : (m_out[i] == 0);
        return int'(e && (m_psc[i] == prv[i] - 1) && lim && !se);
    endfunction

    // One falling edge: check combinational outputs, advance the model,
    // queue expectations, then compare registered outputs after the edge.
    task automatic cyc();
        int  tcv[4];
        bit  ei[4], di[4], li[4], si[4];
        bit  s_eff;
        int  dv;
        exp_t e;
`ifdef COUNT_MOD_SAT_EN
        s_eff = sat;
`else
        s_eff = 1'b0;
`endif
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                ei[i] = (tcv[0] != 0);
                di[i] = 1'b1;
                li[i] = 1'b0;
                si[i] = 1'b0;
            end else begin
                ei[i] = en;
                di[i] = dir;
                li[i] = load;
                si[i] = s_eff;
            end
            tcv[i] = model_valid ? m_tc(i, ei[i], di[i], si[i]) : 0;
            if (model_valid) begin
                check($sformatf("tc%0d", i), dut_tc(i), tcv[i]);
                check($sformatf("zero%0d", i), dut_zero(i), int'(m_out[i] == 0));
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                m_out[i] = 0; m_psc[i] = 0; m_wrap[i] = 0;
            end else if (li[i]) begin
                dv = (i == 3) ? 0 : ((wv[i] == 4) ? int'(din[3:0]) : int'(din));
                m_out[i]  = (dv >= modv[i]) ? modv[i] - 1 : dv;
                m_psc[i]  = 0;
                m_wrap[i] = 0;
            end else if (ei[i]) begin
                m_wrap[i] = 0;
                if (m_psc[i] == prv[i] - 1) begin
                    m_psc[i] = 0;
                    if (di[i]) begin
                        if (m_out[i] == modv[i] - 1) begin
                            if (!si[i]) begin m_out[i] = 0; m_wrap[i] = 1; end
                        end else m_out[i]++;
                    end else begin
                        if (m_out[i] == 0) begin
                            if (!si[i]) begin m_out[i] = modv[i] - 1; m_wrap[i] = 1; end
                        end else m_out[i]--;
                    end
                end else begin
                    m_psc[i]++;
                end
            end else begin
                m_wrap[i] = 0;
            end
        end
        if (reset) model_valid = 1'b1;
        if (model_valid) begin
            for (int i = 0; i < 4; i++) begin
                e.idx = i; e.outc = m_out[i]; e.wrap = m_wrap[i];
                sb.push_back(e);
            end
        end
        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("outc%0d", e.idx), dut_outc(e.idx), e.outc);
            check($sformatf("wrap%0d", e.idx), dut_wrap(e.idx), e.wrap);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    int wraps;
    bit pat[9] = '{1, 1, 0, 1, 1, 0, 0, 1, 1};

    initial begin
        reset = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; sat = 1'b0; din = '0;
        @(negedge clk);
        #1;
        do_reset();
        check("rst_outc_a", int'(a_outc), 0);
        check("rst_zero_a", int'(a_zero), 1);

        // Wrap-up, PRESC=1
        en = 1'b1; dir = 1'b1; wraps = 0;
        repeat (12) begin
            cyc();
            wraps += int'(a_wrap);
        end
        check("up_final_a", int'(a_outc), 2);
        check("up_wraps_a", wraps, 1);

        // Down-wrap through the prescaler with enable gaps
        do_reset();
        dir = 1'b0;
        foreach (pat[k]) begin
            en = pat[k];
            cyc();
            if (k == 3) check("down_first_b", int'(b_outc), 9);
        end
        check("down_final_b", int'(b_outc), 8);

        // Load clamp and priority
        en = 1'b1; dir = 1'b1; load = 1'b1; din = 5'd13;
        cyc();
        check("load_clamp_a", int'(a_outc), 9);
        check("load_wrap_a", int'(a_wrap), 0);
        din = 5'd10;
        cyc();
        check("load_eq_mod_a", int'(a_outc), 9);
        reset = 1'b1;
        cyc();
        check("rst_over_load_a", int'(a_outc), 0);
        reset = 1'b0; load = 1'b0; din = 5'd9;
        load = 1'b1;
        cyc();
        load = 1'b0;
        cyc();
        check("load_then_wrap_a", int'(a_outc), 0);

        // Full range, MODULO = 2^WIDTH
        do_reset();
        en = 1'b1; dir = 1'b1;
        repeat (33) cyc();
        check("full_up_c", int'(c_outc), 1);
        dir = 1'b0;
        repeat (2) cyc();
        check("full_down_c", int'(c_outc), 31);

        // Cascade: 100 enabled edges bring both stages back to 0
        do_reset();
        en = 1'b1; dir = 1'b1;
        repeat (100) cyc();
        check("casc_s0", int'(a_outc), 0);
        check("casc_s1", int'(s1_outc), 0);

        // Saturate select
        do_reset();
        sat = 1'b1; en = 1'b1; dir = 1'b1;
        repeat (15) cyc();
`ifdef COUNT_MOD_SAT_EN
        check("sat_up_a", int'(a_outc), 9);
`else
        check("sat_up_a", int'(a_outc), 5);
`endif
        dir = 1'b0;
        repeat (12) cyc();
`ifdef COUNT_MOD_SAT_EN
        check("sat_down_a", int'(a_outc), 0);
`else
        check("sat_down_a", int'(a_outc), 3);
`endif
        sat = 1'b0;

        // Random mix of all controls
        repeat (150) begin
            reset = ($urandom_range(0, 30) == 0);
            load  = ($urandom_range(0, 10) == 0);
            en    = ($urandom_range(0, 3) != 0);
            dir   = $urandom_range(0, 1) != 0;
            sat   = $urandom_range(0, 1) != 0;
            din   = 5'($urandom_range(0, 31));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
